serial_sub: RTL and testbench
=============================

SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits.
REQ-002 SHALL have parameter DIGIT, default 1: bits subtracted per cycle; WIDTH SHALL be an integer multiple of DIGIT.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request; a, b, bin sampled on the same edge.
REQ-006 SHALL have port a  input  WIDTH  minuend.
REQ-007 SHALL have port b  input  WIDTH  subtrahend.
REQ-008 SHALL have port bin  input  1  borrow-in.
REQ-009 SHALL have port busy  output  1  high while state is RUN.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-011 SHALL have port d  output  WIDTH  difference a - b - bin, modulo 2^WIDTH.
REQ-012 SHALL have port bo  output  1  borrow-out of the MSB digit.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE or DONE with start=1 SHALL latch a, b, bin, clear digit counter, go to RUN.
REQ-015 DONE with start=0 SHALL go to IDLE; DONE lasts exactly one cycle.
REQ-016 Each RUN cycle SHALL subtract digit k (bits k*DIGIT+DIGIT-1 .. k*DIGIT), LSB digit first, using the registered borrow as digit borrow-in, store the difference bits into d and the digit borrow-out into the borrow register.
REQ-017 After digit WIDTH/DIGIT-1, RUN SHALL go to DONE; done SHALL rise on the (WIDTH/DIGIT)-th rising edge after the edge sampling start.
REQ-018 start while busy=1 SHALL be ignored; latched operands and progress unaffected.
REQ-019 d and bo SHALL hold final values from DONE until the next accepted start; during RUN d is partial and undefined for consumers.
REQ-020 start asserted in the DONE cycle SHALL be accepted (back-to-back, no IDLE cycle).
REQ-021 Digit counter SHALL be $clog2(WIDTH/DIGIT) bits minimum (1 bit when WIDTH/DIGIT=1) and SHALL NOT wrap inside one operation.
REQ-022 DIGIT=WIDTH SHALL give single RUN cycle, done on the 1st edge after start.

Reset
REQ-023 rst=1 at a rising edge SHALL force IDLE, busy=0, done=0, d=0, bo=0, borrow and counter=0, overriding start.
REQ-024 rst during RUN SHALL abort the operation with no done pulse.

Configuration
REQ-025 Macro SERIAL_SUB_OVF_EN defined SHALL add output ovf  1: signed two's-complement overflow of a - b - bin, valid and held with d; reset 0.
REQ-026 Macro SERIAL_SUB_OVF_EN undefined SHALL omit port ovf and its logic; all other behaviour identical.

Structure
REQ-027 Package serial_sub_pkg SHALL hold the state enum type (IDLE, RUN, DONE) and state encoding constants.
REQ-028 Sub-module sub_digit SHALL be a parametrised DIGIT-bit combinational ripple subtractor (x, y, bi -> diff, bo), instantiated once.

Verification
REQ-029 WIDTH=8, DIGIT=1: a=0x05, b=0x03, bin=0 -> d=0x02, bo=0, done on 8th edge after start, busy high 8 cycles.
REQ-030 WIDTH=8, DIGIT=1: a=0x00, b=0x01, bin=0 -> d=0xFF, bo=1; then a=0xFF, b=0xFF, bin=1 back-to-back from DONE -> d=0xFF, bo=1.
REQ-031 WIDTH=8, DIGIT=4: a=0x5A, b=0x3C, bin=0 -> d=0x1E, bo=0, done on 2nd edge after start.
REQ-032 Start a=0x10, b=0x01; pulse start with a=0x00, b=0x00 at 3rd RUN cycle -> ignored, d=0x0F, bo=0.
REQ-033 rst asserted at 4th RUN cycle -> next cycle IDLE, busy=0, d=0, bo=0, no done pulse; a subsequent start completes normally.
REQ-034 SERIAL_SUB_OVF_EN defined, WIDTH=8: a=0x80, b=0x01, bin=0 -> d=0x7F, bo=0, ovf=1; a=0x05, b=0x03 -> ovf=0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor (serial_sub).
package serial_sub_pkg;

   localparam logic [1:0] StateIdleEnc = 2'd0;
   localparam logic [1:0] StateRunEnc  = 2'd1;
   localparam logic [1:0] StateDoneEnc = 2'd2;

   typedef enum logic [1:0] {
      StIdle = StateIdleEnc,
      StRun  = StateRunEnc,
      StDone = StateDoneEnc
   } state_e;

   // Counter width for n digits; a single-digit operation still needs one bit.
   function automatic int unsigned cnt_bits(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sub_digit.sv
// DIGIT-bit combinational ripple subtractor: diff = x - y - bi, bo = borrow out.
module sub_digit #(
   parameter int unsigned DIGIT = 1
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             bi,
   output logic [DIGIT-1:0] diff,
   output logic             bo
);

   logic [DIGIT:0] br;

   always_comb begin
      br    = '0;
      diff  = '0;
      br[0] = bi;
      for (int i = 0; i < int'(DIGIT); i++) begin
         diff[i]  = x[i] ^ y[i] ^ br[i];
         br[i+1]  = (~x[i] & (y[i] | br[i])) | (y[i] & br[i]);
      end
      bo = br[DIGIT];
   end

endmodule

// File: rtl/serial_sub.sv
// Digit-serial subtractor, LSB digit first, DIGIT bits per cycle.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] d,
   output logic             bo
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned NDIG = WIDTH / DIGIT;
   localparam int unsigned CW   = cnt_bits(NDIG);
   localparam logic [CW-1:0] LastDigit = CW'(NDIG - 1);

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] d_q;
   logic             borrow_q;
   logic             bo_q;
   logic             busy_q;
   logic             done_q;
   logic [CW-1:0]    cnt_q;
`ifdef SERIAL_SUB_OVF_EN
   logic             ovf_q;
`endif

   logic [31:0]      base;
   logic [DIGIT-1:0] dig_x;
   logic [DIGIT-1:0] dig_y;
   logic [DIGIT-1:0] dig_diff;
   logic             dig_bo;

   always_comb begin
      base  = 32'(cnt_q) * DIGIT;
      dig_x = a_q[base +: DIGIT];
      dig_y = b_q[base +: DIGIT];
   end

   sub_digit #(
      .DIGIT(DIGIT)
   ) u_sub_digit (
      .x    (dig_x),
      .y    (dig_y),
      .bi   (borrow_q),
      .diff (dig_diff),
      .bo   (dig_bo)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         a_q      <= '0;
         b_q      <= '0;
         d_q      <= '0;
         borrow_q <= 1'b0;
         bo_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
`ifdef SERIAL_SUB_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  a_q      <= a;
                  b_q      <= b;
                  borrow_q <= bin;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= StRun;
               end else begin
                  state_q  <= StIdle;
               end
            end
            StRun: begin
               // start is deliberately not looked at here: operands stay locked.
               d_q[base +: DIGIT] <= dig_diff;
               borrow_q           <= dig_bo;
               if (cnt_q == LastDigit) begin
                  bo_q    <= dig_bo;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= StDone;
`ifdef SERIAL_SUB_OVF_EN
                  // Overflow: operand signs differ and result sign differs from a.
                  ovf_q   <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) &
                             (dig_diff[DIGIT-1] ^ a_q[WIDTH-1]);
`endif
               end else begin
                  cnt_q   <= cnt_q + 1'b1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   always_comb begin
      busy = busy_q;
      done = done_q;
      d    = d_q;
      bo   = bo_q;
`ifdef SERIAL_SUB_OVF_EN
      ovf  = ovf_q;
`endif
   end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: dut0 is WIDTH=8/DIGIT=1, dut1 is WIDTH=8/DIGIT=4.
module tb_serial_sub;

   typedef struct {
      logic [7:0] d;
      logic       bo;
      logic       ovf;
      int         cyc;
      int         nbusy;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       start [2];
   logic [7:0] a     [2];
   logic [7:0] b     [2];
   logic       bin   [2];
   logic       busy  [2];
   logic       done  [2];
   logic [7:0] d     [2];
   logic       bo    [2];
`ifdef SERIAL_SUB_OVF_EN
   logic       ovf   [2];
`endif

   exp_t sb0[$];
   exp_t sb1[$];
   int   ntests   = 0;
   int   nfail    = 0;
   int   pcyc     = 0;
   int   busy_cnt [2];
   exp_t mon_e;
   bit   mon_have;

   serial_sub #(
      .WIDTH(8),
      .DIGIT(1)
   ) u_dut0 (
      .clk   (clk),
      .rst   (rst),
      .start (start[0]),
      .a     (a[0]),
      .b     (b[0]),
      .bin   (bin[0]),
      .busy  (busy[0]),
      .done  (done[0]),
      .d     (d[0]),
      .bo    (bo[0])
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf   (ovf[0])
`endif
   );

   serial_sub #(
      .WIDTH(8),
      .DIGIT(4)
   ) u_dut1 (
      .clk   (clk),
      .rst   (rst),
      .start (start[1]),
      .a     (a[1]),
      .b     (b[1]),
      .bin   (bin[1]),
      .busy  (busy[1]),
      .done  (done[1]),
      .d     (d[1]),
      .bo    (bo[1])
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf   (ovf[1])
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) pcyc <= pcyc + 1;

   task automatic chk(input string name, input int k, input logic [31:0] act,
                      input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, k, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever a DUT pulses done.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (done[k] === 1'b1) begin
            mon_have = 1'b0;
            if (k == 0 && sb0.size() > 0) begin
               mon_e = sb0.pop_front();
               mon_have = 1'b1;
            end
            if (k == 1 && sb1.size() > 0) begin
               mon_e = sb1.pop_front();
               mon_have = 1'b1;
            end
            if (!mon_have) begin
               ntests++;
               nfail++;
               $display("FAIL unexpected_done dut%0d: got done=1, expected no pulse at cycle %0d",
                        k, pcyc);
            end else begin
               chk("d", k, 32'(d[k]), 32'(mon_e.d));
               chk("bo", k, 32'(bo[k]), 32'(mon_e.bo));
`ifdef SERIAL_SUB_OVF_EN
               chk("ovf", k, 32'(ovf[k]), 32'(mon_e.ovf));
`endif
               chk("done_cycle", k, pcyc, mon_e.cyc);
               chk("busy_cycles", k, busy_cnt[k], mon_e.nbusy);
            end
         end
         if (busy[k] === 1'b1) busy_cnt[k]++;
         else busy_cnt[k] = 0;
      end
   end

   // Drive one start pulse from a negedge; returns at the following negedge.
   task automatic issue(input int k, input logic [7:0] av, input logic [7:0] bv,
                        input logic bi, input bit push, input logic [7:0] ed,
                        input logic eb, input logic eo, input int n);
      exp_t e;
      start[k] = 1'b1;
      a[k]     = av;
      b[k]     = bv;
      bin[k]   = bi;
      if (push) begin
         e.d     = ed;
         e.bo    = eb;
         e.ovf   = eo;
         e.cyc   = pcyc + 1 + n;
         e.nbusy = n;
         if (k == 0) sb0.push_back(e);
         else sb1.push_back(e);
      end
      @(negedge clk);
      start[k] = 1'b0;
   endtask

   task automatic wait_done(input int k);
      int n = 0;
      while (done[k] !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (done[k] !== 1'b1) begin
         ntests++;
         nfail++;
         $display("FAIL timeout dut%0d: got no done within 40 cycles, expected done", k);
      end
   endtask

   initial begin
      busy_cnt[0] = 0;
      busy_cnt[1] = 0;
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         start[k] = 1'b0;
         a[k]     = '0;
         b[k]     = '0;
         bin[k]   = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("rst_busy", k, 32'(busy[k]), 0);
         chk("rst_done", k, 32'(done[k]), 0);
         chk("rst_d", k, 32'(d[k]), 0);
         chk("rst_bo", k, 32'(bo[k]), 0);
      end
      rst = 1'b0;
      @(negedge clk);

      // Basic subtraction, bit-serial.
      issue(0, 8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 8);
      wait_done(0);
      repeat (3) @(negedge clk);
      chk("hold_d", 0, 32'(d[0]), 32'h02);
      chk("hold_bo", 0, 32'(bo[0]), 0);

      // Underflow, then back-to-back start in the DONE cycle.
      issue(0, 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 8);
      wait_done(0);
      issue(0, 8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 8);
      wait_done(0);
      @(negedge clk);

      // Nibble-serial.
      issue(1, 8'h5A, 8'h3C, 1'b0, 1'b1, 8'h1E, 1'b0, 1'b0, 2);
      wait_done(1);
      issue(1, 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 2);
      wait_done(1);
      @(negedge clk);

      // start during RUN must be ignored.
      issue(0, 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0, 8);
      @(negedge clk);
      start[0] = 1'b1;
      a[0]     = 8'h00;
      b[0]     = 8'h00;
      @(negedge clk);
      start[0] = 1'b0;
      wait_done(0);
      @(negedge clk);

      // Reset in the 4th RUN cycle aborts with no done pulse.
      issue(0, 8'h33, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 0, 32'(busy[0]), 0);
      chk("abort_done", 0, 32'(done[0]), 0);
      chk("abort_d", 0, 32'(d[0]), 0);
      chk("abort_bo", 0, 32'(bo[0]), 0);
      repeat (10) @(negedge clk);
      issue(0, 8'h20, 8'h05, 1'b1, 1'b1, 8'h1A, 1'b0, 1'b0, 8);
      wait_done(0);
      @(negedge clk);

      // Signed overflow cases (ovf only compared when the port exists).
      issue(0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 8);
      wait_done(0);
      issue(0, 8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 8);
      wait_done(0);
      issue(1, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 2);
      wait_done(1);

      repeat (12) @(negedge clk);
      chk("sb0_empty", 0, sb0.size(), 0);
      chk("sb1_empty", 1, sb1.size(), 0);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000 time units, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
